// File: rtl/gray_serial_rx.sv
// Receive stage of the gray-count serial link: requests a frame, deserialises the
// marker-prefixed gray word, converts it to binary and strobes done/err.
module gray_serial_rx #(
  parameter int DATA_W       = 8,
  parameter int HUNT_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              b_start,
  input  logic              a_clk_en,
  input  logic              a_gray_data,
  output logic              en_handshake,
  output logic              b_done,
  output logic              b_err,
  output logic              b_busy,
  output logic [DATA_W-1:0] b_gray_word,
  output logic [DATA_W-1:0] b_bin_cnt
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int TO_W  = $clog2(HUNT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HUNT,
    S_SHIFT,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0] gray_q, gray_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [DATA_W-1:0] shift_next;
  logic [DATA_W-1:0] bin_next;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    gray_d     = gray_q;
    bin_d      = bin_q;
    shift_next = {shift_q[DATA_W-2:0], a_gray_data};
    bin_next   = '0;
    // Each binary bit is the XOR of all gray bits at and above it.
    for (int i = 0; i < DATA_W; i++) begin
      bin_next[i] = ^(shift_next >> i);
    end

    case (state_q)
      S_IDLE: begin
        if (b_start) state_d = S_REQ;
      end
      S_REQ: begin
        if (!a_clk_en) begin
          state_d  = S_HUNT;
          to_cnt_d = '0;
        end
      end
      S_HUNT: begin
        if (a_clk_en) begin
          state_d = S_ERR;
        end else if (a_gray_data) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_q == TO_W'(HUNT_TIMEOUT - 1)) state_d = S_ERR;
        end
      end
      S_SHIFT: begin
        if (a_clk_en) begin
          state_d = S_ERR;
          shift_d = '0;
        end else begin
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          // Result registers load on the edge that enters DONE, with the final bit included.
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            state_d = S_DONE;
            gray_d  = shift_next;
            bin_d   = bin_next;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      gray_q    <= '0;
      bin_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      gray_q    <= gray_d;
      bin_q     <= bin_d;
    end
  end

  assign en_handshake = (state_q == S_REQ);
  assign b_done       = (state_q == S_DONE);
  assign b_err        = (state_q == S_ERR);
  assign b_busy       = (state_q != S_IDLE);
  assign b_gray_word  = gray_q;
  assign b_bin_cnt    = bin_q;

endmodule
